data_mem_resp: RTL and testbench



---
 rtl/data_mem_resp.sv | 227 ++++++++++++++++++++++
 tb/tb_data_mem_resp.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_resp.sv
// data_mem_resp: memory-side responder for the core's data_mem_re/we/size
// interface. Big-endian byte-addressable RAM with byte/halfword/word access,
// programmable wait states, and rejection of malformed requests.
// Optional feature macro: DMEM_ERR_CAPTURE_EN (first-error address capture).
module data_mem_resp #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        re_in,
  input  logic        we_in,
  input  logic [1:0]  size_in,
  input  logic        signed_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        stall_out,
  output logic        valid_out,
  output logic [31:0] rdata_out,
  output logic        err_out,
  output logic [31:0] err_addr_out,
  output logic        err_flag_out
);

  localparam int unsigned IDX_W = ADDR_WIDTH - 2;
  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_AFTER_REQ = (WAIT_STATES == 0) ? ST_DONE : ST_WAIT;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_RSVD = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  logic [1:0]       state, next_state;
  logic [CNT_W-1:0] cnt, cnt_next;

  logic        cap_re, cap_we, cap_sgn;
  logic [1:0]  cap_size;
  logic [31:0] cap_addr, cap_wdata;

  logic        req_re, req_we, req_sgn;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_err;
  logic        commit;

  logic [IDX_W-1:0] word_idx;
  logic [31:0]      rd_word;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [31:0]      load_val;
  logic [3:0]       wmask;
  logic [31:0]      wword;

  logic [31:0] mem [DEPTH];

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  // Next-state, wait counter and stall generation
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    stall_out  = 1'b0;
    case (state)
      ST_IDLE: begin
        stall_out = re_in | we_in;
        if (re_in | we_in) begin
          cnt_next   = CNT_W'(WAIT_STATES);
          next_state = ST_AFTER_REQ;
        end
      end
      ST_WAIT: begin
        stall_out = 1'b1;
        if (cnt <= CNT_W'(1)) begin
          cnt_next   = '0;
          next_state = ST_DONE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Capture the request on acceptance; core holds inputs but WAIT ignores them
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cap_re    <= 1'b0;
      cap_we    <= 1'b0;
      cap_sgn   <= 1'b0;
      cap_size  <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if (state == ST_IDLE && (re_in | we_in)) begin
      cap_re    <= re_in;
      cap_we    <= we_in;
      cap_sgn   <= signed_in;
      cap_size  <= size_in;
      cap_addr  <= addr_in;
      cap_wdata <= wdata_in;
    end
  end

  // Effective request: live inputs in IDLE (zero-wait path), captured otherwise
  always_comb begin
    if (state == ST_IDLE) begin
      req_re    = re_in;
      req_we    = we_in;
      req_sgn   = signed_in;
      req_size  = size_in;
      req_addr  = addr_in;
      req_wdata = wdata_in;
    end else begin
      req_re    = cap_re;
      req_we    = cap_we;
      req_sgn   = cap_sgn;
      req_size  = cap_size;
      req_addr  = cap_addr;
      req_wdata = cap_wdata;
    end
  end

  // Request validity and the commit strobe on the edge entering DONE
  always_comb begin
    req_err = (req_re & req_we)
            | (req_size == SZ_RSVD)
            | ((req_size == SZ_HALF) & req_addr[0])
            | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00))
            | ((req_addr >> ADDR_WIDTH) != 32'd0);
    commit  = (next_state == ST_DONE);
  end

  // Big-endian lane extraction and extension for loads
  always_comb begin
    word_idx = req_addr[ADDR_WIDTH-1:2];
    rd_word  = mem[word_idx];
    case (req_addr[1:0])
      2'd0:    rd_byte = rd_word[31:24];
      2'd1:    rd_byte = rd_word[23:16];
      2'd2:    rd_byte = rd_word[15:8];
      default: rd_byte = rd_word[7:0];
    endcase
    rd_half = req_addr[1] ? rd_word[15:0] : rd_word[31:16];
    case (req_size)
      SZ_BYTE: load_val = {{24{req_sgn & rd_byte[7]}}, rd_byte};
      SZ_HALF: load_val = {{16{req_sgn & rd_half[15]}}, rd_half};
      SZ_WORD: load_val = rd_word;
      default: load_val = '0;
    endcase
  end

  // Big-endian lane placement and byte-enable mask for stores
  always_comb begin
    case (req_size)
      SZ_BYTE: begin
        wword = {4{req_wdata[7:0]}};
        wmask = 4'b1000 >> req_addr[1:0];
      end
      SZ_HALF: begin
        wword = {2{req_wdata[15:0]}};
        wmask = req_addr[1] ? 4'b0011 : 4'b1100;
      end
      SZ_WORD: begin
        wword = req_wdata;
        wmask = 4'b1111;
      end
      default: begin
        wword = '0;
        wmask = 4'b0000;
      end
    endcase
  end

  // RAM write port: only legal stores commit, and only the addressed lanes
  always_ff @(posedge clk_in) begin
    if (rst_n_in && commit && req_we && !req_err) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) mem[word_idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  // Response outputs: one-cycle valid/err pulse, rdata held until next DONE
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_out <= 1'b0;
      err_out   <= 1'b0;
      rdata_out <= '0;
    end else begin
      valid_out <= commit;
      err_out   <= commit & req_err;
      if (commit) rdata_out <= (req_err || !req_re) ? 32'd0 : load_val;
    end
  end

`ifdef DMEM_ERR_CAPTURE_EN
  // Sticky record of the first rejected request since reset
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      err_addr_out <= '0;
      err_flag_out <= 1'b0;
    end else if (commit && req_err && !err_flag_out) begin
      err_addr_out <= req_addr;
      err_flag_out <= 1'b1;
    end
  end
`else
  assign err_addr_out = '0;
  assign err_flag_out = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp: directed test-plan steps plus
// randomized accesses against a byte-array reference model.
module tb_data_mem_resp;

  localparam int unsigned AW   = 10;
  localparam int unsigned WS_A = 2;
  localparam int unsigned WS_B = 0;
  localparam logic [31:0] A_LIMIT = 32'(1 << AW);

  logic clk = 1'b0;
  logic rst_n;

  logic        a_re, a_we, a_sgn;
  logic [1:0]  a_size;
  logic [31:0] a_addr, a_wdata;
  logic        a_stall, a_valid, a_err, a_err_flag;
  logic [31:0] a_rdata, a_err_addr;

  logic        b_re, b_we, b_sgn;
  logic [1:0]  b_size;
  logic [31:0] b_addr, b_wdata;
  logic        b_stall, b_valid, b_err, b_err_flag;
  logic [31:0] b_rdata, b_err_addr;

  logic [7:0]  mem_m [1 << AW];
  logic        first_err_seen;
  logic [31:0] first_err_addr;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  data_mem_resp #(.ADDR_WIDTH(AW), .WAIT_STATES(WS_A)) u_dut_a (
    .clk_in(clk), .rst_n_in(rst_n),
    .re_in(a_re), .we_in(a_we), .size_in(a_size), .signed_in(a_sgn),
    .addr_in(a_addr), .wdata_in(a_wdata),
    .stall_out(a_stall), .valid_out(a_valid), .rdata_out(a_rdata),
    .err_out(a_err), .err_addr_out(a_err_addr), .err_flag_out(a_err_flag)
  );

  data_mem_resp #(.ADDR_WIDTH(AW), .WAIT_STATES(WS_B)) u_dut_b (
    .clk_in(clk), .rst_n_in(rst_n),
    .re_in(b_re), .we_in(b_we), .size_in(b_size), .signed_in(b_sgn),
    .addr_in(b_addr), .wdata_in(b_wdata),
    .stall_out(b_stall), .valid_out(b_valid), .rdata_out(b_rdata),
    .err_out(b_err), .err_addr_out(b_err_addr), .err_flag_out(b_err_flag)
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic sgn,
                                           input logic [31:0] addr);
    int a;
    logic [15:0] h;
    a = int'(addr[AW-1:0]);
    case (size)
      2'b00:   return sgn ? {{24{mem_m[a][7]}}, mem_m[a]} : {24'd0, mem_m[a]};
      2'b01: begin
        h = {mem_m[a], mem_m[a+1]};
        return sgn ? {{16{h[15]}}, h} : {16'd0, h};
      end
      default: return {mem_m[a], mem_m[a+1], mem_m[a+2], mem_m[a+3]};
    endcase
  endfunction

  task automatic ref_store(input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wd);
    int a;
    a = int'(addr[AW-1:0]);
    case (size)
      2'b00: mem_m[a] = wd[7:0];
      2'b01: begin
        mem_m[a]   = wd[15:8];
        mem_m[a+1] = wd[7:0];
      end
      default: begin
        mem_m[a]   = wd[31:24];
        mem_m[a+1] = wd[23:16];
        mem_m[a+2] = wd[15:8];
        mem_m[a+3] = wd[7:0];
      end
    endcase
  endtask

  task automatic chk_capture(input string tag);
`ifdef DMEM_ERR_CAPTURE_EN
    chk32({tag, "_err_addr"}, a_err_addr, first_err_seen ? first_err_addr : 32'd0);
    chk1({tag, "_err_flag"}, a_err_flag, first_err_seen);
`else
    chk32({tag, "_err_addr"}, a_err_addr, 32'd0);
    chk1({tag, "_err_flag"}, a_err_flag, 1'b0);
`endif
  endtask

  // One full access on instance A: timing of stall/valid, response and model update.
  task automatic access_a(input logic re, input logic we, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic lit_en, input logic [31:0] lit_rdata, input string tag);
    logic        err_e;
    logic [31:0] rd_e;
    err_e = (re && we) || (size == 2'b10) || (size == 2'b01 && addr[0]) ||
            (size == 2'b11 && addr[1:0] != 2'b00) || (addr >= A_LIMIT);
    rd_e = 32'd0;
    if (!err_e && re) rd_e = ref_load(size, sgn, addr);
    @(posedge clk); #1;
    a_re = re; a_we = we; a_size = size; a_sgn = sgn; a_addr = addr; a_wdata = wdata;
    for (int k = 0; k <= int'(WS_A); k++) begin
      @(negedge clk);
      chk1({tag, "_stall"}, a_stall, 1'b1);
      chk1({tag, "_valid_early"}, a_valid, 1'b0);
      @(posedge clk); #1;
    end
    if (!err_e && we) ref_store(size, addr, wdata);
    if (err_e && !first_err_seen) begin
      first_err_seen = 1'b1;
      first_err_addr = addr;
    end
    @(negedge clk);
    chk1({tag, "_stall_done"}, a_stall, 1'b0);
    chk1({tag, "_valid"}, a_valid, 1'b1);
    chk1({tag, "_err"}, a_err, err_e);
    if (re || err_e) chk32({tag, "_rdata"}, a_rdata, rd_e);
    if (lit_en) chk32({tag, "_rdata_lit"}, a_rdata, lit_rdata);
    chk_capture(tag);
    a_re = 1'b0; a_we = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk1({tag, "_valid_pulse"}, a_valid, 1'b0);
    if (re || err_e) chk32({tag, "_rdata_hold"}, a_rdata, rd_e);
  endtask

  initial begin
    logic        r_re, r_we, r_sgn;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    int          pick;

    rst_n = 1'b0;
    a_re = 1'b0; a_we = 1'b0; a_size = 2'b00; a_sgn = 1'b0; a_addr = '0; a_wdata = '0;
    b_re = 1'b0; b_we = 1'b0; b_size = 2'b00; b_sgn = 1'b0; b_addr = '0; b_wdata = '0;
    first_err_seen = 1'b0;
    first_err_addr = '0;
    for (int i = 0; i < (1 << AW); i++) mem_m[i] = 8'h00;

    // Reset state
    #12;
    chk1("rst_valid", a_valid, 1'b0);
    chk1("rst_err", a_err, 1'b0);
    chk32("rst_rdata", a_rdata, 32'd0);
    chk1("rst_stall", a_stall, 1'b0);
    chk_capture("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Give the exercised window known contents
    for (int i = 0; i < 16; i++)
      access_a(1'b0, 1'b1, 2'b11, 1'b0, 32'(i * 4), $urandom(), 1'b0, 32'd0, "prefill");

    // Directed test-plan steps
    access_a(1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0, "st_w10");
    access_a(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'd0, 1'b1, 32'hDEADBEEF, "ld_w10");
    access_a(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000005A, 1'b0, 32'd0, "st_b11");
    access_a(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'd0, 1'b1, 32'hDE5ABEEF, "ld_w10_b");
    access_a(1'b1, 1'b0, 2'b00, 1'b1, 32'h11, 32'd0, 1'b1, 32'h0000005A, "ld_sb11");
    access_a(1'b0, 1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFFFF80, 1'b0, 32'd0, "st_b12");
    access_a(1'b1, 1'b0, 2'b00, 1'b1, 32'h12, 32'd0, 1'b1, 32'hFFFFFF80, "ld_sb12");
    access_a(1'b1, 1'b0, 2'b00, 1'b0, 32'h12, 32'd0, 1'b1, 32'h00000080, "ld_ub12");
    access_a(1'b1, 1'b0, 2'b01, 1'b0, 32'h13, 32'd0, 1'b1, 32'd0, "ld_h13_mis");
    access_a(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'd0, 1'b1, 32'hDE5A80EF, "ld_w10_c");
    access_a(1'b1, 1'b0, 2'b11, 1'b0, 32'h400, 32'd0, 1'b1, 32'd0, "ld_w400_oor");
    access_a(1'b1, 1'b1, 2'b11, 1'b0, 32'h20, 32'h12345678, 1'b1, 32'd0, "rw_both20");
    access_a(1'b1, 1'b0, 2'b11, 1'b0, 32'h20, 32'd0, 1'b0, 32'd0, "ld_w20");
    access_a(1'b1, 1'b0, 2'b01, 1'b1, 32'h10, 32'd0, 1'b1, 32'hFFFFDE5A, "ld_sh10");
    access_a(1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'd0, 1'b1, 32'h000080EF, "ld_uh12");
    access_a(1'b0, 1'b1, 2'b01, 1'b0, 32'h16, 32'h0000BEEF, 1'b0, 32'd0, "st_h16");
    access_a(1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 32'd0, 1'b1, 32'd0, "ld_rsvd");
    access_a(1'b1, 1'b0, 2'b11, 1'b0, 32'h16, 32'd0, 1'b1, 32'd0, "ld_w16_mis");

    // Randomized accesses against the model
    for (int n = 0; n < 80; n++) begin
      pick  = int'($urandom_range(0, 9));
      r_re  = (pick == 0) || (pick >= 5);
      r_we  = (pick <= 4);
      r_size = 2'($urandom_range(0, 3));
      r_sgn = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) r_addr = $urandom();
      else r_addr = 32'($urandom_range(0, 63));
      access_a(r_re, r_we, r_size, r_sgn, r_addr, $urandom(), 1'b0, 32'd0, "rand");
    end

    // Reset during WAIT of a store to 0x30 aborts it
    @(posedge clk); #1;
    a_re = 1'b0; a_we = 1'b1; a_size = 2'b11; a_addr = 32'h30; a_wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    @(negedge clk);
    chk1("abort_stall_wait", a_stall, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("abort_valid", a_valid, 1'b0);
    chk1("abort_err", a_err, 1'b0);
    chk32("abort_rdata", a_rdata, 32'd0);
    chk32("abort_err_addr", a_err_addr, 32'd0);
    chk1("abort_err_flag", a_err_flag, 1'b0);
    chk1("abort_stall_follow", a_stall, 1'b1);
    a_we = 1'b0;
    #1;
    chk1("abort_stall_idle", a_stall, 1'b0);
    first_err_seen = 1'b0;
    first_err_addr = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("abort_no_valid", a_valid, 1'b0);
    end
    access_a(1'b1, 1'b0, 2'b11, 1'b0, 32'h30, 32'd0, 1'b0, 32'd0, "ld_w30_old");
    access_a(1'b1, 1'b0, 2'b11, 1'b0, 32'h401, 32'd0, 1'b1, 32'd0, "post_rst_err");

    // Zero-wait instance: single-cycle stall and re-acceptance after DONE
    @(posedge clk); #1;
    b_we = 1'b1; b_size = 2'b11; b_addr = 32'h40; b_wdata = 32'hCAFEF00D;
    @(negedge clk);
    chk1("b_st_stall", b_stall, 1'b1);
    chk1("b_st_valid_early", b_valid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("b_st_stall_done", b_stall, 1'b0);
    chk1("b_st_valid", b_valid, 1'b1);
    chk1("b_st_err", b_err, 1'b0);
    b_we = 1'b0;
    @(posedge clk); #1;
    b_re = 1'b1;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      chk1("b_ld_stall", b_stall, 1'b1);
      chk1("b_ld_valid_early", b_valid, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      chk1("b_ld_stall_done", b_stall, 1'b0);
      chk1("b_ld_valid", b_valid, 1'b1);
      chk32("b_ld_rdata", b_rdata, 32'hCAFEF00D);
      @(posedge clk); #1;
    end
    b_re = 1'b0;
    @(negedge clk);
    chk1("b_idle_stall", b_stall, 1'b0);
    chk1("b_idle_valid", b_valid, 1'b0);
    chk32("b_err_addr", b_err_addr, 32'd0);
    chk1("b_err_flag", b_err_flag, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
